// File: rtl/window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : window_accumulator
// Purpose  : Multi-lane windowed accumulator. It sums LANES signed products
//            over a runtime window of 1..MAX_WIN accepted beats, with
//            saturating adds. Each finished window sum goes downstream through
//            a single-slot valid/ready output register.
// Ports    : clk, rst           clock (rising edge) and asynchronous
//                               active-high reset
//            clear_i            synchronous abort of the partial window
//            win_len_i          window length, sampled on the first beat
//            in_valid_i/in_ready_o/in_data_i     input beat handshake and
//                                                lanes
//            out_valid_o/out_ready_i/out_data_o  result slot handshake and
//                                                sums
//            out_sat_o          per-lane flag: the lane saturated in the
//                               window
//            busy_o             a partial window is in progress
// Revision : 1.0  initial release
// ============================================================================
module window_accumulator #(
  parameter int IN_W    = 8,
  parameter int ACC_W   = 16,
  parameter int LANES   = 4,
  parameter int MAX_WIN = 9,
  localparam int CW     = $clog2(MAX_WIN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic [CW-1:0]          win_len_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*IN_W-1:0]  in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [LANES*ACC_W-1:0] out_data_o,
  output logic [LANES-1:0]       out_sat_o,
  output logic                   busy_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          len_q, len_d;
  logic [LANES*ACC_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]       sat_q, sat_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*ACC_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]       out_sat_q, out_sat_d;

  logic [CW-1:0]          w_len_clamp;
  logic [CW-1:0]          w_eff_len;
  logic                   w_last;
  logic                   w_accept;
  logic [LANES*ACC_W-1:0] w_acc_base;
  logic [LANES-1:0]       w_sat_base;
  logic [LANES*ACC_W-1:0] w_sum;
  logic [LANES-1:0]       w_ovf;

  // A zero length means a window of one beat. Oversized lengths are cut
  // down to MAX_WIN.
  always_comb begin
    if (win_len_i == '0)
      w_len_clamp = CW'(1);
    else if (win_len_i > CW'(MAX_WIN))
      w_len_clamp = CW'(MAX_WIN);
    else
      w_len_clamp = win_len_i;
  end

  // In IDLE the window has not been latched yet. The incoming beat's own
  // length therefore decides whether that beat is also the last one.
  assign w_eff_len  = (state_q == S_IDLE) ? w_len_clamp : len_q;
  assign w_last     = (count_q == w_eff_len - CW'(1));
  assign in_ready_o = !clear_i && !(w_last && out_valid_q && !out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;

  // The first beat of a window always adds to zero.
  assign w_acc_base = (state_q == S_IDLE) ? '0 : acc_q;
  assign w_sat_base = (state_q == S_IDLE) ? '0 : sat_q;

  // Per-lane saturating add. The sum is one bit wider than the accumulator.
  // Overflow shows as disagreement between its top two bits.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [ACC_W-1:0] w_a;
    logic signed [IN_W-1:0]  w_x;
    logic signed [ACC_W:0]   w_s;

    assign w_a = w_acc_base[i*ACC_W +: ACC_W];
    assign w_x = in_data_i[i*IN_W +: IN_W];
    assign w_s = {w_a[ACC_W-1], w_a} + {{(ACC_W + 1 - IN_W){w_x[IN_W-1]}}, w_x};
    assign w_ovf[i] = w_s[ACC_W] ^ w_s[ACC_W-1];
    assign w_sum[i*ACC_W +: ACC_W] =
        !w_ovf[i]  ? w_s[ACC_W-1:0] :
        w_s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                     {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    // A handshake empties the slot. A window completing in the same cycle
    // (below) overrides this and reloads the slot.
    if (out_valid_q && out_ready_i)
      out_valid_d = 1'b0;

    if (clear_i) begin
      state_d = S_IDLE;
      count_d = '0;
      acc_d   = '0;
      sat_d   = '0;
    end else if (w_accept) begin
      if (state_q == S_IDLE)
        len_d = w_len_clamp;
      if (w_last) begin
        state_d     = S_IDLE;
        count_d     = '0;
        acc_d       = '0;
        sat_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = w_sum;
        out_sat_d   = w_sat_base | w_ovf;
      end else begin
        state_d = S_ACCUM;
        count_d = count_q + CW'(1);
        acc_d   = w_sum;
        sat_d   = w_sat_base | w_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;
  assign busy_o      = (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_accumulator
// Purpose  : Self-checking bench for window_accumulator. It uses a
//            table-driven set of windows, plus hand-written sequences for
//            backpressure, saturation, clear and asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_window_accumulator;

  logic clk;
  logic rst;

  // DUT A: default parameters (4 lanes, 16-bit accumulators)
  logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [3:0]  a_win_len;
  logic [31:0] a_in_data;
  logic [63:0] a_out_data;
  logic [3:0]  a_out_sat;

  // DUT B: 2 lanes, 8-bit accumulators, for saturation
  logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [3:0]  b_win_len;
  logic [15:0] b_in_data;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_sat;

  int total = 0;
  int bad   = 0;

  window_accumulator u_dut_a (
    .clk(clk), .rst(rst), .clear_i(a_clear), .win_len_i(a_win_len),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_data_o(a_out_data), .out_sat_o(a_out_sat), .busy_o(a_busy)
  );

  window_accumulator #(.IN_W(8), .ACC_W(8), .LANES(2), .MAX_WIN(9)) u_dut_b (
    .clk(clk), .rst(rst), .clear_i(b_clear), .win_len_i(b_win_len),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_data_o(b_out_data), .out_sat_o(b_out_sat), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock: drive at the falling edge, sample at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pack8(input int v0, input int v1, input int v2, input int v3);
    logic [31:0] r;
    r = {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
    return r;
  endfunction

  function automatic logic [63:0] pack16(input int v0, input int v1, input int v2, input int v3);
    logic [63:0] r;
    r = {v3[15:0], v2[15:0], v1[15:0], v0[15:0]};
    return r;
  endfunction

  typedef struct {
    int len_in;   // win_len on the first beat of each window
    int len_mid;  // win_len on the other beats (must be ignored)
    int eff;      // effective window length
    int beats;    // total beats driven back to back
    int v[4];     // lane values, same on every beat
    int e[4];     // expected window sums
  } vec_t;

  vec_t vec[5];

  initial begin
    // Nine beats of {1,2,3,-1}
    vec[0] = '{len_in: 9, len_mid: 9, eff: 9, beats: 9,
               v: '{1, 2, 3, -1}, e: '{9, 18, 27, -9}};
    // Two back-to-back windows of 3 beats of 5
    vec[1] = '{len_in: 3, len_mid: 3, eff: 3, beats: 6,
               v: '{5, 5, 5, 5}, e: '{15, 15, 15, 15}};
    // Length 0 acts as 1: every beat is its own window
    vec[2] = '{len_in: 0, len_mid: 0, eff: 1, beats: 2,
               v: '{7, -7, 0, 1}, e: '{7, -7, 0, 1}};
    // Length 15 clamps to 9; the mid-window change to 2 is ignored
    vec[3] = '{len_in: 15, len_mid: 2, eff: 9, beats: 9,
               v: '{1, -2, 10, 0}, e: '{9, -18, 90, 0}};
    // Extreme 8-bit inputs grow past 8 bits without saturating at 16
    vec[4] = '{len_in: 2, len_mid: 2, eff: 2, beats: 2,
               v: '{127, -128, -1, 100}, e: '{254, -256, -2, 200}};

    rst = 1'b1;
    a_clear = 0; a_win_len = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1;
    b_clear = 0; b_win_len = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_sat", a_out_sat, 0);
    check("rst_busy", a_busy, 0);
    check("rst_in_ready", a_in_ready, 1);
    rst = 1'b0;
    step();

    // Table-driven windows, downstream always ready
    for (int t = 0; t < 5; t++) begin
      for (int b = 0; b < vec[t].beats; b++) begin
        a_win_len  = 4'((b % vec[t].eff == 0) ? vec[t].len_in : vec[t].len_mid);
        a_in_data  = pack8(vec[t].v[0], vec[t].v[1], vec[t].v[2], vec[t].v[3]);
        a_in_valid = 1'b1;
        #1;
        check($sformatf("v%0d_b%0d_in_ready", t, b), a_in_ready, 1);
        step();
        if (b % vec[t].eff == vec[t].eff - 1) begin
          check($sformatf("v%0d_b%0d_out_valid", t, b), a_out_valid, 1);
          check($sformatf("v%0d_b%0d_out_data", t, b), a_out_data,
                pack16(vec[t].e[0], vec[t].e[1], vec[t].e[2], vec[t].e[3]));
          check($sformatf("v%0d_b%0d_out_sat", t, b), a_out_sat, 0);
        end else begin
          check($sformatf("v%0d_b%0d_no_early_valid", t, b), a_out_valid, 0);
        end
      end
      a_in_valid = 1'b0;
      step();
      check($sformatf("v%0d_drained", t), a_out_valid, 0);
      check($sformatf("v%0d_idle", t), a_busy, 0);
    end

    // Backpressure: last beat stalls while the old result is held
    a_out_ready = 1'b0;
    a_win_len = 4'd1; a_in_data = pack8(3, 3, 3, 3); a_in_valid = 1'b1;
    step();
    check("bp_pending_valid", a_out_valid, 1);
    check("bp_pending_data", a_out_data, pack16(3, 3, 3, 3));
    a_win_len = 4'd3; a_in_data = pack8(4, 4, 4, 4);
    #1 check("bp_beat1_ready", a_in_ready, 1);
    step();
    #1 check("bp_beat2_ready", a_in_ready, 1);
    step();
    #1 check("bp_beat3_stalled", a_in_ready, 0);
    step();
    check("bp_hold_data", a_out_data, pack16(3, 3, 3, 3));
    check("bp_hold_busy", a_busy, 1);
    #1 check("bp_still_stalled", a_in_ready, 0);
    a_out_ready = 1'b1;
    #1 check("bp_release_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    check("bp_reload_valid", a_out_valid, 1);
    check("bp_reload_data", a_out_data, pack16(12, 12, 12, 12));
    step();
    check("bp_drained", a_out_valid, 0);

    // Saturation on the 8-bit accumulator instance
    b_win_len = 4'd4; b_in_data = 16'h9C64; b_in_valid = 1'b1;  // {-100, +100}
    for (int i = 0; i < 4; i++) step();
    b_in_valid = 1'b0;
    check("sat_valid", b_out_valid, 1);
    check("sat_data", b_out_data, 16'h807F);
    check("sat_flags", b_out_sat, 2'b11);
    b_win_len = 4'd1; b_in_data = 16'h0101; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    check("sat_cleared_data", b_out_data, 16'h0101);
    check("sat_cleared_flags", b_out_sat, 2'b00);

    // clear after 4 of 9 beats
    a_win_len = 4'd9; a_in_data = pack8(1, 1, 1, 1); a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("clr_busy_before", a_busy, 1);
    a_clear = 1'b1;
    #1 check("clr_in_ready", a_in_ready, 0);
    step();
    a_clear = 1'b0;
    check("clr_busy_after", a_busy, 0);
    check("clr_slot_untouched", a_out_valid, 0);
    a_out_ready = 1'b0;
    a_in_data = pack8(2, 2, 2, 2);
    for (int i = 0; i < 9; i++) step();
    check("clr_fresh_valid", a_out_valid, 1);
    check("clr_fresh_data", a_out_data, pack16(18, 18, 18, 18));

    // Asynchronous reset mid-window with a result pending
    a_in_data = pack8(1, 1, 1, 1);
    step();
    step();
    a_in_valid = 1'b0;
    check("arst_busy_before", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", a_out_valid, 0);
    check("arst_out_data", a_out_data, 0);
    check("arst_busy", a_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b1;
    #1 check("arst_in_ready", a_in_ready, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
